sprot_xfer_mon: RTL and testbench

SPROT_XFER_MON -- requirements
Module: sprot_xfer_mon

---
 rtl/sprot_xfer_mon.sv | 113 +++++++++++
 tb/tb_sprot_xfer_mon.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sprot_xfer_mon.sv
// sprot_xfer_mon: monitors a start -> a -> b handshake, flags protocol
// violations with a code, and counts completed transfers and violations.
// All outputs are registered; the next-state logic decides each cycle whether
// the current sample completes a transfer or breaks the protocol.
module sprot_xfer_mon (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       a,
  input  logic       b,
  input  logic       err_clr,
  output logic       prot_err,
  output logic       xfer_end,
  output logic [1:0] err_code,
  output logic       err_sticky,
  output logic       busy,
  output logic [7:0] xfer_cnt,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_A = 2'd1,
    WAIT_B = 2'd2
  } state_t;

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_MISS_A  = 2'b01;
  localparam logic [1:0] CODE_MISS_B  = 2'b10;
  localparam logic [1:0] CODE_OVERLAP = 2'b11;

  state_t     state;
  state_t     state_nxt;
  logic       done;
  logic       viol;
  logic [1:0] viol_code;

  // Counters hold at full scale instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // State register; reset discards any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decision plus the per-sample completion/violation flags.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    viol      = 1'b0;
    viol_code = CODE_NONE;
    case (state)
      IDLE: begin
        if (start) state_nxt = WAIT_A;
      end
      WAIT_A: begin
        if (start) begin
          // A new start restarts the transfer, regardless of a.
          viol      = 1'b1;
          viol_code = CODE_OVERLAP;
          state_nxt = WAIT_A;
        end else if (a) begin
          state_nxt = WAIT_B;
        end else begin
          viol      = 1'b1;
          viol_code = CODE_MISS_A;
          state_nxt = IDLE;
        end
      end
      WAIT_B: begin
        if (b) begin
          done = 1'b1;
        end else begin
          viol      = 1'b1;
          viol_code = CODE_MISS_B;
        end
        // start during WAIT_B is a legal back-to-back request either way.
        state_nxt = start ? WAIT_A : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs; a violation outranks a simultaneous err_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prot_err   <= 1'b0;
      xfer_end   <= 1'b0;
      err_code   <= CODE_NONE;
      err_sticky <= 1'b0;
      busy       <= 1'b0;
      xfer_cnt   <= 8'd0;
      err_cnt    <= 8'd0;
    end else begin
      prot_err <= viol;
      xfer_end <= done;
      busy     <= (state_nxt != IDLE);
      if (viol) begin
        err_code   <= viol_code;
        err_sticky <= 1'b1;
        err_cnt    <= sat_inc(err_cnt);
      end else if (err_clr) begin
        err_code   <= CODE_NONE;
        err_sticky <= 1'b0;
      end
      if (done) xfer_cnt <= sat_inc(xfer_cnt);
    end
  end

endmodule

// File: tb/tb_sprot_xfer_mon.sv
// tb_sprot_xfer_mon: directed protocol scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_sprot_xfer_mon;

  logic       clk = 1'b0;
  logic       rst_n, start, a, b, err_clr;
  logic       prot_err, xfer_end, err_sticky, busy;
  logic [1:0] err_code;
  logic [7:0] xfer_cnt, err_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: how far the current transfer has progressed
  // (0 = none open, 1 = start seen, 2 = start and a seen).
  int m_progress = 0;
  int m_perr = 0, m_xend = 0, m_code = 0, m_sticky = 0;
  int m_xcnt = 0, m_ecnt = 0;

  sprot_xfer_mon dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .err_clr   (err_clr),
    .prot_err  (prot_err),
    .xfer_end  (xfer_end),
    .err_code  (err_code),
    .err_sticky(err_sticky),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // Apply the spec's rules to one sampled input set.
  task automatic model(input bit s, input bit pa, input bit pb, input bit clr, input bit rn);
    int v, d, c;
    v = 0; d = 0; c = 0;
    if (!rn) begin
      m_progress = 0; m_perr = 0; m_xend = 0; m_code = 0;
      m_sticky = 0; m_xcnt = 0; m_ecnt = 0;
      return;
    end
    if (m_progress == 0) begin
      if (s) m_progress = 1;
    end else if (m_progress == 1) begin
      if (s)       begin v = 1; c = 3; end
      else if (pa) m_progress = 2;
      else         begin v = 1; c = 1; m_progress = 0; end
    end else begin
      if (pb) d = 1;
      else    begin v = 1; c = 2; end
      m_progress = s ? 1 : 0;
    end
    m_perr = v;
    m_xend = d;
    if (v != 0) begin
      m_code = c; m_sticky = 1; m_ecnt = sat(m_ecnt + 1);
    end else if (clr) begin
      m_code = 0; m_sticky = 0;
    end
    if (d != 0) m_xcnt = sat(m_xcnt + 1);
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare everything.
  task automatic step(input bit s, input bit pa, input bit pb, input bit clr, input bit rn);
    start = s; a = pa; b = pb; err_clr = clr; rst_n = rn;
    @(posedge clk);
    model(s, pa, pb, clr, rn);
    #1;
    chk("prot_err",   prot_err,   m_perr);
    chk("xfer_end",   xfer_end,   m_xend);
    chk("err_code",   err_code,   m_code);
    chk("err_sticky", err_sticky, m_sticky);
    chk("busy",       busy,       (m_progress != 0) ? 1 : 0);
    chk("xfer_cnt",   xfer_cnt,   m_xcnt);
    chk("err_cnt",    err_cnt,    m_ecnt);
    chk("excl",       prot_err & xfer_end, 0);
  endtask

  initial begin
    start = 0; a = 0; b = 0; err_clr = 0; rst_n = 0;
    #2;
    // Reset state
    step(1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", xfer_cnt, 0);

    // Legal transfer
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("legal_end", xfer_end, 1);
    chk("legal_cnt", xfer_cnt, 1);
    step(0, 0, 0, 0, 1);
    chk("legal_end_once", xfer_end, 0);

    // Missing a
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("miss_a_perr", prot_err, 1);
    chk("miss_a_code", err_code, 1);
    chk("miss_a_busy", busy, 0);
    step(0, 0, 0, 1, 1);
    chk("clr_sticky", err_sticky, 0);

    // Back-to-back
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 1);
    chk("b2b_end1", xfer_end, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("b2b_end2", xfer_end, 1);
    chk("b2b_cnt", xfer_cnt, 3);

    // Overlap
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    chk("ovl_perr", prot_err, 1);
    chk("ovl_code", err_code, 3);
    step(0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    chk("ovl_end", xfer_end, 1);

    // Saturation of xfer_cnt, then clear collides with a missing b
    for (int i = 0; i < 260; i++) begin
      step(1, 0, 0, 0, 1);
      step(0, 1, 0, 0, 1);
      step(0, 0, 1, 0, 1);
    end
    chk("sat_xcnt", xfer_cnt, 255);
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    chk("clrwin_sticky", err_sticky, 1);
    chk("clrwin_code", err_code, 2);

    // Reset mid-transfer in WAIT_B
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 1);
    chk("midrst_end", xfer_end, 0);
    chk("midrst_xcnt", xfer_cnt, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(99) < 30),
           ($urandom_range(99) < 75),
           ($urandom_range(99) < 75),
           ($urandom_range(99) < 10),
           ($urandom_range(999) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
